// File: rtl/wb_common_pkg.sv
// Wishbone B3 cycle/burst encodings and the ownership state shared by the RAM arbiter slice.
package wb_common_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Encoding matches the one-hot grant vector so debug views line up.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_OWN0 = 2'b01,
      ARB_OWN1 = 2'b10
   } arb_state_e;

endpackage

// File: rtl/wb_ram_arbiter_2m_if.sv
// One Wishbone B3 point-to-point link; master modport drives the request, slave modport the terminations.
interface wb_ram_arbiter_2m_if #(
   parameter int dw = 32,
   parameter int aw = 32
);
   logic [aw-1:0]   adr;
   logic [1:0]      bte;
   logic [2:0]      cti;
   logic            cyc;
   logic            stb;
   logic            we;
   logic [dw/8-1:0] sel;
   logic [dw-1:0]   wr_dat;
   logic [dw-1:0]   rd_dat;
   logic            ack;
   logic            err;
   logic            rty;

   modport master (
      output adr, bte, cti, cyc, stb, we, sel, wr_dat,
      input  rd_dat, ack, err, rty
   );

   modport slave (
      input  adr, bte, cti, cyc, stb, we, sel, wr_dat,
      output rd_dat, ack, err, rty
   );
endinterface

// File: rtl/wb_rr_arb2.sv
// Ownership register for two Wishbone masters: round-robin on contention, held for the whole cyc window.
// One-cycle registered grant latency; a dropped owner cyc hands over directly to a waiting master.
module wb_rr_arb2
   import wb_common_pkg::*;
#(
   parameter int default_owner = 0
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       cyc0,
   input  logic       cyc1,
   output arb_state_e state,
   output logic [1:0] grant_o
);

   // rr_ptr = 1 means master 1 wins the next tie.
   logic rr_ptr;
   logic rearb;

   assign rearb = (state == ARB_IDLE) ||
                  (state == ARB_OWN0 && !cyc0) ||
                  (state == ARB_OWN1 && !cyc1);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state   <= ARB_IDLE;
         rr_ptr  <= (default_owner != 0);
         grant_o <= 2'b00;
      end else if (rearb) begin
         if (cyc0 && (!cyc1 || !rr_ptr)) begin
            state   <= ARB_OWN0;
            grant_o <= 2'b01;
            rr_ptr  <= 1'b1;
         end else if (cyc1) begin
            state   <= ARB_OWN1;
            grant_o <= 2'b10;
            rr_ptr  <= 1'b0;
         end else begin
            state   <= ARB_IDLE;
            grant_o <= 2'b00;
         end
      end
   end

endmodule

// File: rtl/wb_ram_arbiter_2m.sv
// Shares one Wishbone RAM slave between two masters; request mux and response demux follow the registered owner.
// Grant arrives the cycle after cyc rises; the non-owner simply waits with its cyc held, bursts are never split.
module wb_ram_arbiter_2m
   import wb_common_pkg::*;
#(
   parameter int dw            = 32,
   parameter int aw            = 32,
   parameter int default_owner = 0
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   wb_ram_arbiter_2m_if.slave  wbm0,
   wb_ram_arbiter_2m_if.slave  wbm1,
   wb_ram_arbiter_2m_if.master wbs,
   output logic [1:0]          grant_o
);

   arb_state_e state;

   logic [aw-1:0]   s_adr;
   logic [1:0]      s_bte;
   logic [2:0]      s_cti;
   logic            s_cyc;
   logic            s_stb;
   logic            s_we;
   logic [dw/8-1:0] s_sel;
   logic [dw-1:0]   s_dat;
   logic            own0;
   logic            own1;

   wb_rr_arb2 #(
      .default_owner (default_owner)
   ) u_arb (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .cyc0     (wbm0.cyc),
      .cyc1     (wbm1.cyc),
      .state    (state),
      .grant_o  (grant_o)
   );

   // Muxing from the registered state means a dropping owner is seen by the slave as cyc=0 for a cycle.
   always_comb begin
      s_adr = '0;
      s_bte = BTE_LINEAR;
      s_cti = CTI_CLASSIC;
      s_cyc = 1'b0;
      s_stb = 1'b0;
      s_we  = 1'b0;
      s_sel = '0;
      s_dat = '0;
      case (state)
         ARB_OWN0: begin
            s_adr = wbm0.adr;
            s_bte = wbm0.bte;
            s_cti = wbm0.cti;
            s_cyc = wbm0.cyc;
            s_stb = wbm0.stb;
            s_we  = wbm0.we;
            s_sel = wbm0.sel;
            s_dat = wbm0.wr_dat;
         end
         ARB_OWN1: begin
            s_adr = wbm1.adr;
            s_bte = wbm1.bte;
            s_cti = wbm1.cti;
            s_cyc = wbm1.cyc;
            s_stb = wbm1.stb;
            s_we  = wbm1.we;
            s_sel = wbm1.sel;
            s_dat = wbm1.wr_dat;
         end
         default: ;
      endcase
   end

   assign wbs.adr    = s_adr;
   assign wbs.bte    = s_bte;
   assign wbs.cti    = s_cti;
   assign wbs.cyc    = s_cyc;
   assign wbs.stb    = s_stb;
   assign wbs.we     = s_we;
   assign wbs.sel    = s_sel;
   assign wbs.wr_dat = s_dat;

   assign own0 = (state == ARB_OWN0);
   assign own1 = (state == ARB_OWN1);

   assign wbm0.ack    = wbs.ack & own0;
   assign wbm0.err    = wbs.err & own0;
   assign wbm0.rty    = wbs.rty & own0;
   assign wbm0.rd_dat = wbs.rd_dat;

   assign wbm1.ack    = wbs.ack & own1;
   assign wbm1.err    = wbs.err & own1;
   assign wbm1.rty    = wbs.rty & own1;
   assign wbm1.rd_dat = wbs.rd_dat;

endmodule

// File: tb/tb_wb_ram_arbiter_2m.sv
// Bench for the two-master RAM arbiter: vector table, random run against an ownership model, and bus sequences.
module tb_wb_ram_arbiter_2m;
   import wb_common_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] grant;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   wb_ram_arbiter_2m_if #(.dw(32), .aw(32)) m0_if ();
   wb_ram_arbiter_2m_if #(.dw(32), .aw(32)) m1_if ();
   wb_ram_arbiter_2m_if #(.dw(32), .aw(32)) s_if ();

   logic [31:0] m_adr [2];
   logic [31:0] m_dat [2];
   logic [2:0]  m_cti [2];
   logic [1:0]  m_bte [2];
   logic        m_cyc [2];
   logic        m_stb [2];
   logic        m_we  [2];
   logic [3:0]  m_sel [2];
   logic        m_ack [2];
   logic        m_err [2];
   logic [31:0] m_rdat [2];

   assign m0_if.adr = m_adr[0];  assign m1_if.adr = m_adr[1];
   assign m0_if.bte = m_bte[0];  assign m1_if.bte = m_bte[1];
   assign m0_if.cti = m_cti[0];  assign m1_if.cti = m_cti[1];
   assign m0_if.cyc = m_cyc[0];  assign m1_if.cyc = m_cyc[1];
   assign m0_if.stb = m_stb[0];  assign m1_if.stb = m_stb[1];
   assign m0_if.we  = m_we[0];   assign m1_if.we  = m_we[1];
   assign m0_if.sel = m_sel[0];  assign m1_if.sel = m_sel[1];
   assign m0_if.wr_dat = m_dat[0];  assign m1_if.wr_dat = m_dat[1];
   assign m_ack[0] = m0_if.ack;  assign m_ack[1] = m1_if.ack;
   assign m_err[0] = m0_if.err;  assign m_err[1] = m1_if.err;
   assign m_rdat[0] = m0_if.rd_dat;  assign m_rdat[1] = m1_if.rd_dat;

   wb_ram_arbiter_2m #(.dw(32), .aw(32), .default_owner(0)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbm0     (m0_if),
      .wbm1     (m1_if),
      .wbs      (s_if),
      .grant_o  (grant)
   );

   // RAM slave: 4 KiB, one registered ack per strobe, err outside the array.
   logic [31:0] mem [0:1023];
   logic [31:0] ack_log [$];
   assign s_if.rty = 1'b0;
   always @(posedge clk) begin
      if (rst) begin
         s_if.ack <= 1'b0;
         s_if.err <= 1'b0;
      end else if (s_if.cyc && s_if.stb && !s_if.ack && !s_if.err) begin
         if (s_if.adr < 32'h1000) begin
            s_if.ack <= 1'b1;
            ack_log.push_back(s_if.adr);
            if (s_if.we) mem[s_if.adr[11:2]] <= s_if.wr_dat;
            s_if.rd_dat <= mem[s_if.adr[11:2]];
         end else begin
            s_if.err <= 1'b1;
         end
      end else begin
         s_if.ack <= 1'b0;
         s_if.err <= 1'b0;
      end
   end

   // Grant trace: every cycle, plus the sequence of new grants (0 = m0, 1 = m1).
   logic [1:0] gtrace [$];
   int         glog [$];
   logic [1:0] gprev = 2'b00;
   always @(posedge clk) begin
      #1;
      gtrace.push_back(grant);
      if (grant != gprev && grant != 2'b00) glog.push_back(grant == 2'b10 ? 1 : 0);
      gprev = grant;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_master(input int m);
      m_cyc[m] = 1'b0;  m_stb[m] = 1'b0;  m_we[m] = 1'b0;
      m_adr[m] = '0;    m_dat[m] = '0;    m_sel[m] = 4'hf;
      m_cti[m] = CTI_CLASSIC;  m_bte[m] = BTE_LINEAR;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_master(0);
      idle_master(1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Classic single transfer; cyc is held low across one edge afterwards so cycles never merge.
   task automatic xfer(input int m, input logic [31:0] adr, input logic we, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ok);
      @(negedge clk);
      m_adr[m] = adr;  m_we[m] = we;  m_dat[m] = wd;  m_sel[m] = 4'hf;
      m_cti[m] = CTI_CLASSIC;  m_bte[m] = BTE_LINEAR;
      m_cyc[m] = 1'b1;  m_stb[m] = 1'b1;
      ok = 1'b0;
      rd = '0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(posedge clk); #1;
         if (m_ack[m] || m_err[m]) begin
            ok = 1'b1;
            rd = m_rdat[m];
         end
      end
      m_cyc[m] = 1'b0;  m_stb[m] = 1'b0;  m_we[m] = 1'b0;
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL xfer_timeout m%0d: got no termination, required ack or err", m);
      end
      @(posedge clk);
   endtask

   typedef struct {
      logic       rst;
      logic       c0;
      logic       c1;
      logic [1:0] g;
      logic       scyc;
   } vec_t;
   vec_t vec [14];

   logic [31:0] rd;
   logic        ok;
   int          own;
   int          fav;
   logic [1:0]  exp_g;
   int          beats;
   logic        flag, e0, e1, a0;
   time         t_m1_done, t_m0_done;
   logic [31:0] wrap_adr [4];

   initial begin
      idle_master(0);
      idle_master(1);

      // ---- arbitration vectors (stb low, so the RAM stays silent) ----
      vec[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      vec[1]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
      vec[2]  = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b1};
      vec[3]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
      vec[4]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
      vec[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
      vec[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      vec[7]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
      vec[8]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
      vec[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
      vec[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      vec[11] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
      vec[12] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
      vec[13] = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b1};
      for (int i = 0; i < 14; i++) begin
         rst = vec[i].rst;
         m_cyc[0] = vec[i].c0;
         m_cyc[1] = vec[i].c1;
         @(negedge clk);
         check($sformatf("vec%0d_grant", i), grant, vec[i].g);
         check($sformatf("vec%0d_wbs_cyc", i), s_if.cyc, vec[i].scyc);
         if (i == 0) begin
            check("reset_ack0", m_ack[0], 1'b0);
            check("reset_ack1", m_ack[1], 1'b0);
            check("reset_wbs_stb", s_if.stb, 1'b0);
            check("reset_wbs_we", s_if.we, 1'b0);
            check("reset_wbs_cti", s_if.cti, CTI_CLASSIC);
         end
      end
      do_reset();

      // ---- random traffic against the ownership model ----
      own = -1;
      fav = 0;
      for (int i = 0; i < 300; i++) begin
         rst = (i == 0) || ($urandom_range(0, 39) == 0);
         for (int m = 0; m < 2; m++) begin
            m_cyc[m] = ($urandom_range(0, 3) != 0);
            m_stb[m] = $urandom_range(0, 1);
            m_we[m]  = $urandom_range(0, 1);
            m_dat[m] = $urandom;
            m_adr[m] = ($urandom_range(0, 7) == 0) ? 32'h0010_0000 : (32'($urandom_range(0, 1023)) << 2);
         end
         if (rst) begin
            own = -1;
            fav = 0;
         end else if (own < 0 || !m_cyc[own]) begin
            if (m_cyc[0] && m_cyc[1]) own = fav;
            else if (m_cyc[0]) own = 0;
            else if (m_cyc[1]) own = 1;
            else own = -1;
            if (own >= 0) fav = 1 - own;
         end
         @(negedge clk);
         exp_g = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
         check("rnd_grant", grant, exp_g);
         if (own < 0) begin
            check("rnd_wbs_cyc", s_if.cyc, 1'b0);
            check("rnd_wbs_adr", s_if.adr, 32'h0);
         end else begin
            check("rnd_wbs_cyc", s_if.cyc, m_cyc[own]);
            check("rnd_wbs_adr", s_if.adr, m_adr[own]);
            check("rnd_wbs_we", s_if.we, m_we[own]);
         end
         check("rnd_ack0", m_ack[0], s_if.ack && own == 0);
         check("rnd_ack1", m_ack[1], s_if.ack && own == 1);
         check("rnd_err0", m_err[0], s_if.err && own == 0);
         check("rnd_err1", m_err[1], s_if.err && own == 1);
         check("rnd_dat1", m_rdat[1], s_if.rd_dat);
      end
      do_reset();

      // ---- single master classic read, grant latency ----
      xfer(1, 32'h10, 1'b1, 32'hDEADBEEF, rd, ok);
      @(negedge clk);
      m_adr[0] = 32'h10;  m_we[0] = 1'b0;  m_cyc[0] = 1'b1;  m_stb[0] = 1'b1;
      #1;
      check("lat_wbs_cyc_before", s_if.cyc, 1'b0);
      @(posedge clk); #1;
      check("lat_wbs_cyc_after", s_if.cyc, 1'b1);
      check("lat_grant", grant, 2'b01);
      ok = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         flag = flag | m_ack[1];
         if (m_ack[0]) begin ok = 1'b1; rd = m_rdat[0]; end
      end
      check("rd_ack0", ok, 1'b1);
      check("rd_data", rd, 32'hDEADBEEF);
      check("rd_no_ack1", flag, 1'b0);
      idle_master(0);
      @(posedge clk);
      do_reset();

      // ---- simultaneous requests, direct handover ----
      @(negedge clk);
      gtrace.delete();
      glog.delete();
      fork
         begin : sim_m0
            logic [31:0] r; logic o;
            xfer(0, 32'h0, 1'b1, 32'h11111111, r, o);
         end
         begin : sim_m1
            logic [31:0] r; logic o;
            xfer(1, 32'h4, 1'b1, 32'h22222222, r, o);
         end
      join
      check("sim_ngrants", glog.size(), 2);
      if (glog.size() >= 2) begin
         check("sim_first_m0", glog[0], 0);
         check("sim_second_m1", glog[1], 1);
      end
      flag = 1'b0;
      for (int i = 1; i < gtrace.size(); i++) begin
         if (gtrace[i] == 2'b10 && !flag) begin
            flag = 1'b1;
            check("sim_no_gap", gtrace[i-1], 2'b01);
         end
      end
      check("sim_handover_seen", flag, 1'b1);
      check("sim_ram0", mem[0], 32'h11111111);
      check("sim_ram4", mem[1], 32'h22222222);

      // ---- m1 wrap-4 burst, m0 requests during beat 2 ----
      wrap_adr[0] = 32'h18;  wrap_adr[1] = 32'h1C;  wrap_adr[2] = 32'h10;  wrap_adr[3] = 32'h14;
      @(negedge clk);
      ack_log.delete();
      m_adr[1] = wrap_adr[0];  m_cti[1] = CTI_INCR;  m_bte[1] = BTE_WRAP4;
      m_we[1] = 1'b0;  m_cyc[1] = 1'b1;  m_stb[1] = 1'b1;
      beats = 0;
      flag = 1'b1;
      t_m1_done = 0;
      t_m0_done = 0;
      fork
         begin
            for (int i = 0; i < 100 && beats < 4; i++) begin
               @(posedge clk); #1;
               if (grant !== 2'b10 || m_ack[0]) flag = 1'b0;
               if (m_ack[1]) begin
                  beats++;
                  if (beats < 4) m_adr[1] = wrap_adr[beats];
                  m_cti[1] = (beats == 3) ? CTI_EOB : CTI_INCR;
               end
            end
            idle_master(1);
            t_m1_done = $time;
         end
         begin : burst_m0
            logic [31:0] r; logic o;
            for (int i = 0; i < 100 && beats < 1; i++) @(posedge clk);
            xfer(0, 32'h0, 1'b0, 32'h0, r, o);
            t_m0_done = $time;
            check("burst_m0_read", r, 32'h11111111);
         end
      join
      check("burst_beats", beats, 4);
      check("burst_grant_hold", flag, 1'b1);
      check("burst_m0_after_m1", (t_m1_done != 0) && (t_m0_done > t_m1_done), 1'b1);
      check("burst_log_size", ack_log.size() >= 4, 1'b1);
      for (int i = 0; i < 4 && i < ack_log.size(); i++)
         check($sformatf("burst_adr%0d", i), ack_log[i], wrap_adr[i]);

      // ---- error routing, grant held until cyc drops ----
      @(negedge clk);
      m_adr[0] = 32'h0010_0000;  m_we[0] = 1'b0;  m_cyc[0] = 1'b1;  m_stb[0] = 1'b1;
      @(posedge clk); #1;
      m_cyc[1] = 1'b1;  m_stb[1] = 1'b0;
      e0 = 1'b0;  e1 = 1'b0;  a0 = 1'b0;
      for (int i = 0; i < 20 && !e0; i++) begin
         @(posedge clk); #1;
         e0 = e0 | m_err[0];
         e1 = e1 | m_err[1];
         a0 = a0 | m_ack[0];
      end
      m_stb[0] = 1'b0;
      check("err_m0", e0, 1'b1);
      check("err_m1", e1, 1'b0);
      check("err_no_ack0", a0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("err_hold%0d", i), grant, 2'b01);
      end
      m_cyc[0] = 1'b0;
      @(posedge clk); #1;
      check("err_release_to_m1", grant, 2'b10);
      m_cyc[1] = 1'b0;
      @(posedge clk); #1;
      check("err_idle", grant, 2'b00);
      idle_master(0);
      idle_master(1);

      // ---- fairness: both masters back-to-back ----
      do_reset();
      glog.delete();
      fork
         begin : fair_m0
            logic [31:0] r; logic o;
            for (int k = 0; k < 8; k++) xfer(0, 32'h100 + 32'(k) * 8, 1'b1, 32'(k), r, o);
         end
         begin : fair_m1
            logic [31:0] r; logic o;
            for (int k = 0; k < 8; k++) xfer(1, 32'h104 + 32'(k) * 8, 1'b1, 32'(k), r, o);
         end
      join
      check("fair_ngrants", glog.size(), 16);
      for (int i = 0; i < 16 && i < glog.size(); i++)
         check($sformatf("fair_grant%0d", i), glog[i], i % 2);

      // ---- reset during an m0 burst ----
      @(negedge clk);
      m_adr[0] = 32'h40;  m_cti[0] = CTI_INCR;  m_bte[0] = BTE_LINEAR;
      m_we[0] = 1'b0;  m_cyc[0] = 1'b1;  m_stb[0] = 1'b1;
      beats = 0;
      for (int i = 0; i < 50 && beats < 1; i++) begin
         @(posedge clk); #1;
         if (m_ack[0]) begin
            beats++;
            m_adr[0] = m_adr[0] + 32'd4;
         end
      end
      check("rstb_first_beat", beats, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstb_grant", grant, 2'b00);
      check("rstb_wbs_cyc", s_if.cyc, 1'b0);
      flag = m_ack[0] | m_ack[1] | m_err[0] | m_err[1];
      @(negedge clk);
      rst = 1'b0;
      idle_master(0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         flag = flag | m_ack[0] | m_ack[1] | m_err[0] | m_err[1];
      end
      check("rstb_no_stray_term", flag, 1'b0);
      check("rstb_idle_grant", grant, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_ram_arbiter_2m.md
Name: wb_ram_arbiter_2m

Overview:
- Two-master, one-slave Wishbone B3 arbiter that shares a single on-chip RAM slave between two requesters, e.g. instruction fetch (m0) and data port (m1).
- Ownership is round-robin at cycle granularity.
- Once a master owns the slave, it keeps it for its whole wb_cyc window, so classic, constant-address and incrementing/wrapping bursts are never split.
- Sits directly in front of the RAM slave; the slave needs no changes.

Parameters:
- dw, 32, data width; sel width is dw/8.
- aw, 32, address width.
- default_owner, 0, master favoured on the first arbitration after reset (round-robin pointer reset value).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- wbm0_adr_i/wbm1_adr_i  in  aw  master address
- wbm0_bte_i/wbm1_bte_i  in  2  burst type extension
- wbm0_cti_i/wbm1_cti_i  in  3  cycle type identifier
- wbm0_cyc_i/wbm1_cyc_i  in  1  cycle (bus request)
- wbm0_stb_i/wbm1_stb_i  in  1  strobe
- wbm0_we_i/wbm1_we_i  in  1  write enable
- wbm0_sel_i/wbm1_sel_i  in  dw/8  byte selects
- wbm0_dat_i/wbm1_dat_i  in  dw  write data
- wbm0_dat_o/wbm1_dat_o  out  dw  read data (slave data broadcast)
- wbm0_ack_o/wbm1_ack_o, wbm0_err_o/wbm1_err_o, wbm0_rty_o/wbm1_rty_o  out  1  per-master termination
- wbs_adr_o, wbs_bte_o, wbs_cti_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_dat_o  out  (widths as above)  muxed request to RAM
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  1  slave terminations
- wbs_dat_i  in  dw  slave read data
- grant_o  out  2  one-hot current owner; 00 = idle (debug/perf)

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset is synchronous and active-high on wb_rst_i.
- State machine: IDLE, OWN0, OWN1. Reset → IDLE, rr pointer = default_owner, grant_o = 00.
- Arbitration: evaluated at a posedge when state is IDLE, or when the current owner's cyc_i is 0.
  - Candidates are masters with cyc_i = 1.
  - One candidate → that master.
  - Both → the master the rr pointer favours.
  - None → IDLE.
- rr pointer: on every new grant it is set to favour the non-granted master.
- Direct handover: OWN0 → OWN1 (and the reverse) happens in one edge when the owner drops cyc while the other requests. There are no idle gap cycles.
- Grant latency: a request from IDLE reaches the slave the cycle after cyc_i first rises. The minimum is one cycle of arbitration latency, by design (registered grant).
- Ownership hold: while the owner's cyc_i = 1, the state never changes, regardless of the other master, stb gaps, or cti values. The owner's cyc_i = 0 is the only release.
- Slave request mux (combinational from the registered state):
  - OWNn: wbs_* = wbmn_*.
  - IDLE: wbs_cyc_o = wbs_stb_o = wbs_we_o = 0, wbs_cti_o = 000, other fields = 0.
  - The cycle a master's cyc falls, the slave therefore sees cyc = 0 for that master, so its registered ack state clears before the next owner is forwarded.
- Response routing:
  - wbmn_ack_o = wbs_ack_i & (state == OWNn); same rule for err and rty.
  - A non-owner never sees ack, err or rty.
  - wbm0_dat_o = wbm1_dat_o = wbs_dat_i.
- Error bursts: a slave err does not release the grant. Release still waits for the owner's cyc to drop.
- Reset mid-cycle: state → IDLE at the reset edge; slave outputs idle in the next cycle. No terminations are generated for the aborted transfer.
- Outputs at reset: all wbm*_ack/err/rty_o = 0, all wbs_* control = 0, grant_o = 00.

Decomposition:
- Shared package (wb_common_pkg):
  - CTI encodings: CLASSIC 000, CONST 001, INCR 010, EOB 111.
  - BTE encodings: LINEAR 00, WRAP4 01, WRAP8 10, WRAP16 11.
  - Arbiter state enum.
- One sub-module: wb_rr_arb2, holding the state register, rr pointer and next-owner logic (~60 lines).
- The top level does the mux/demux (~120 lines).

Test Plan:
- Reset and single master:
  - Stimulus: reset, then m0 does a classic read at adr 0x10 with RAM word 0xDEADBEEF.
  - Response: wbs_cyc_o rises one cycle after wbm0_cyc_i; wbm0_ack_o pulses with wbm0_dat_o = 0xDEADBEEF; wbm1_ack_o stays 0; grant_o = 01.
- Simultaneous requests:
  - Stimulus: after reset (default_owner = 0), m0 and m1 raise cyc on the same cycle with single writes 0x11111111 to 0x0 and 0x22222222 to 0x4.
  - Response: m0 is served first; handover happens with no gap cycle (grant_o 01 → 10 in one edge); RAM 0x0 = 0x11111111 and 0x4 = 0x22222222.
- Burst not split:
  - Stimulus: m1 runs a 4-beat wrap INCR burst at 0x18, the last beat cti = 111; m0 requests at beat 2.
  - Response: m1 gets 4 acks with addresses 0x18, 0x1C, 0x10, 0x14; m0 is granted only after m1's cyc drops; grant_o stays 10 throughout the burst.
- Fairness:
  - Stimulus: both masters hold continuous back-to-back single-transfer cycles for 8 cycles each.
  - Response: grants alternate 0, 1, 0, 1…; no master gets two consecutive grants while the other is requesting.
- Error routing:
  - Stimulus: m0 accesses out-of-range adr 0x0010_0000.
  - Response: wbm0_err_o = 1, wbm1_err_o = 0, grant held until m0 drops cyc.
- Reset mid-burst:
  - Stimulus: wb_rst_i asserted at beat 2 of an m0 burst.
  - Response: next cycle grant_o = 00 and wbs_cyc_o = 0; no stray ack to either master.
